// File: rtl/mxint8_block_collector.sv
// Collects a serial MXINT8 stream (one E8M0 scale beat, then BLOCK_SIZE INT8 element beats)
// into a parallel block and presents it downstream over a valid/ready handshake.
module mxint8_block_collector #(
  parameter int unsigned ELEMENT_WIDTH = 8,
  parameter int unsigned SCALE_WIDTH   = 8,
  parameter int unsigned BLOCK_SIZE    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [ELEMENT_WIDTH-1:0] i_data,
  input  logic                     i_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [SCALE_WIDTH-1:0]   o_scale,
  output logic [ELEMENT_WIDTH-1:0] o_mxint8_elements [0:BLOCK_SIZE-1],
  output logic                     o_frame_err
);

  localparam int unsigned CntWidth = $clog2(BLOCK_SIZE);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    StScale,
    StElem,
    StFull
  } state_e;

  state_e                   r_state;
  logic [CntWidth-1:0]      r_cnt;
  logic                     r_frame_err;
  logic [SCALE_WIDTH-1:0]   r_scale;
  logic [ELEMENT_WIDTH-1:0] r_elems [0:BLOCK_SIZE-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StScale;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
      r_scale     <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        r_elems[i] <= '0;
      end
    end else begin
      r_frame_err <= 1'b0;
      unique case (r_state)
        StScale: begin
          // i_last on the scale beat carries no meaning and is ignored
          if (i_valid) begin
            r_scale <= i_data[SCALE_WIDTH-1:0];
            r_cnt   <= '0;
            r_state <= StElem;
          end
        end
        StElem: begin
          if (i_valid) begin
            r_elems[r_cnt] <= i_data;
            if (r_cnt == CntLast) begin
              // A missing last still completes the block, but is flagged
              r_state     <= StFull;
              r_frame_err <= ~i_last;
            end else if (i_last) begin
              r_state     <= StScale;
              r_cnt       <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StFull: begin
          if (i_ready) begin
            r_state <= StScale;
          end
        end
        default: r_state <= StScale;
      endcase
    end
  end

  logic w_full;
  assign w_full = (r_state == StFull);

  assign o_ready           = ~w_full;
  assign o_valid           = w_full;
  assign o_scale           = r_scale;
  assign o_mxint8_elements = r_elems;
  assign o_frame_err       = r_frame_err;

endmodule

// File: tb/tb_mxint8_block_collector.sv
// Directed bench for mxint8_block_collector: normal blocks, backpressure, framing errors,
// random bubbles and resets mid-block / in FULL.
module tb_mxint8_block_collector;

  localparam int BS = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic       i_last;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_scale;
  logic [7:0] o_mxint8_elements [0:BS-1];
  logic       o_frame_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_scale;
  logic [7:0] exp_el [BS];

  // Monitor: counts observed events; tests compare differences against expectations
  int         deliv_cnt = 0;
  int         valid_cycles = 0;
  int         ferr_cnt = 0;
  logic [7:0] cap_scale;
  logic [7:0] cap_el [BS];

  mxint8_block_collector #(
    .ELEMENT_WIDTH(8),
    .SCALE_WIDTH  (8),
    .BLOCK_SIZE   (BS)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_data           (i_data),
    .i_last           (i_last),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_scale          (o_scale),
    .o_mxint8_elements(o_mxint8_elements),
    .o_frame_err      (o_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_frame_err) ferr_cnt++;
      if (o_valid) valid_cycles++;
      if (o_valid && i_ready) begin
        deliv_cnt++;
        cap_scale = o_scale;
        for (int i = 0; i < BS; i++) cap_el[i] = o_mxint8_elements[i];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input int bubble_pct);
    while (bubble_pct > 0 && int'($urandom_range(99)) < bubble_pct) begin
      i_valid = 1'b0;
      tick();
    end
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    tick();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  // Sends the scale beat then exp_el[0..n_send-1]; i_last on index last_at (-1 for none)
  task automatic stream_block(input int n_send, input int last_at, input int bubble_pct,
                              input logic scale_last);
    send_beat(exp_scale, scale_last, bubble_pct);
    for (int k = 0; k < n_send; k++) send_beat(exp_el[k], (k == last_at), bubble_pct);
  endtask

  task automatic do_reset;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    i_last  = 1'b0;
    i_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int payload_bad();
    int bad = 0;
    if (cap_scale !== exp_scale) bad++;
    for (int i = 0; i < BS; i++) if (cap_el[i] !== exp_el[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset;
    int nz;
    do_reset();
    nz = 0;
    for (int i = 0; i < BS; i++) if (o_mxint8_elements[i] !== 8'h00) nz++;
    checks++;
    if ({o_ready, o_valid, o_frame_err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/vld/err=%b required 100", {o_ready, o_valid, o_frame_err});
    end
    checks++;
    if (o_scale !== 8'h00 || nz != 0) begin
      errors++;
      $display("FAIL reset_payload: got scale=%h nonzero_elems=%0d required 00/0", o_scale, nz);
    end
  endtask

  task automatic test_basic;
    int d0 = deliv_cnt, v0 = valid_cycles, f0 = ferr_cnt;
    exp_scale = 8'h7F;
    for (int k = 0; k < BS; k++) exp_el[k] = 8'(k);
    i_ready = 1'b1;
    stream_block(BS, BS - 1, 0, 1'b1);
    checks++;
    if ({o_valid, o_ready} !== 2'b10) begin
      errors++;
      $display("FAIL basic_full: got vld/rdy=%b required 10", {o_valid, o_ready});
    end
    tick();
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_after: got vld/rdy=%b required 01", {o_valid, o_ready});
    end
    checks++;
    if (deliv_cnt - d0 != 1 || valid_cycles - v0 != 1) begin
      errors++;
      $display("FAIL basic_count: got deliv=%0d vcyc=%0d required 1/1",
               deliv_cnt - d0, valid_cycles - v0);
    end
    checks++;
    if (payload_bad() != 0) begin
      errors++;
      $display("FAIL basic_data: got scale=%h bad=%0d required scale=7f bad=0",
               cap_scale, payload_bad());
    end
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL basic_ferr: got %0d pulses required 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_backpressure;
    int d0 = deliv_cnt;
    exp_scale = 8'h3C;
    for (int k = 0; k < BS; k++) exp_el[k] = 8'(8'hA0 + k);
    i_ready = 1'b0;
    stream_block(BS, BS - 1, 0, 1'b0);
    // Offer junk beats while full; none may be taken
    i_valid = 1'b1;
    i_data  = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      int bad = 0;
      if (o_scale !== exp_scale) bad++;
      for (int i = 0; i < BS; i++) if (o_mxint8_elements[i] !== exp_el[i]) bad++;
      checks++;
      if ({o_valid, o_ready} !== 2'b10 || bad != 0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got vld/rdy=%b bad=%0d required 10/0",
                 c, {o_valid, o_ready}, bad);
      end
      tick();
    end
    i_ready = 1'b1;
    checks++;
    if (deliv_cnt != d0 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_early: got deliv=%0d vld=%b required 0/1", deliv_cnt - d0, o_valid);
    end
    tick();
    i_valid = 1'b0;
    checks++;
    if (deliv_cnt - d0 != 1 || payload_bad() != 0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_deliver: got deliv=%0d bad=%0d vld=%b required 1/0/0",
               deliv_cnt - d0, payload_bad(), o_valid);
    end
  endtask

  task automatic test_early_last;
    int d0 = deliv_cnt, f0 = ferr_cnt;
    exp_scale = 8'h11;
    for (int k = 0; k < BS; k++) exp_el[k] = 8'(8'h40 + k);
    stream_block(10, 9, 0, 1'b0);
    checks++;
    if ({o_frame_err, o_valid, o_ready} !== 3'b101) begin
      errors++;
      $display("FAIL early_pulse: got err/vld/rdy=%b required 101",
               {o_frame_err, o_valid, o_ready});
    end
    tick();
    checks++;
    if (o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL early_width: got err=%b required 0", o_frame_err);
    end
    exp_scale = 8'h80;
    for (int k = 0; k < BS; k++) exp_el[k] = 8'(8'h80 + k);
    stream_block(BS, BS - 1, 0, 1'b0);
    tick();
    checks++;
    if (deliv_cnt - d0 != 1 || payload_bad() != 0 || ferr_cnt - f0 != 1) begin
      errors++;
      $display("FAIL early_next: got deliv=%0d bad=%0d ferr=%0d required 1/0/1",
               deliv_cnt - d0, payload_bad(), ferr_cnt - f0);
    end
  endtask

  task automatic test_missing_last;
    int d0 = deliv_cnt, f0 = ferr_cnt;
    exp_scale = 8'hC3;
    for (int k = 0; k < BS; k++) exp_el[k] = 8'(8'hFF - k);
    stream_block(BS, -1, 0, 1'b0);
    checks++;
    if ({o_frame_err, o_valid} !== 2'b11) begin
      errors++;
      $display("FAIL miss_pulse: got err/vld=%b required 11", {o_frame_err, o_valid});
    end
    tick();
    checks++;
    if (deliv_cnt - d0 != 1 || payload_bad() != 0 || ferr_cnt - f0 != 1 || o_frame_err !== 0) begin
      errors++;
      $display("FAIL miss_deliver: got deliv=%0d bad=%0d ferr=%0d required 1/0/1",
               deliv_cnt - d0, payload_bad(), ferr_cnt - f0);
    end
  endtask

  task automatic test_bubbles;
    int f0 = ferr_cnt;
    for (int b = 0; b < 3; b++) begin
      int d0 = deliv_cnt;
      int waited = 0;
      exp_scale = 8'($urandom);
      for (int k = 0; k < BS; k++) exp_el[k] = 8'($urandom);
      stream_block(BS, BS - 1, 50, 1'b0);
      while (deliv_cnt == d0 && waited < 10) begin
        tick();
        waited++;
      end
      checks++;
      if (deliv_cnt - d0 != 1 || payload_bad() != 0) begin
        errors++;
        $display("FAIL bubble_blk%0d: got deliv=%0d bad=%0d required 1/0",
                 b, deliv_cnt - d0, payload_bad());
      end
    end
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL bubble_ferr: got %0d pulses required 0", ferr_cnt - f0);
    end
  endtask

  task automatic test_reset_mid;
    int d0 = deliv_cnt, f0 = ferr_cnt, nz;
    exp_scale = 8'h22;
    for (int k = 0; k < BS; k++) exp_el[k] = 8'(8'h60 + k);
    stream_block(17, -1, 0, 1'b0);
    // Reset lands on element 17 while a beat is also offered
    rst = 1'b1; i_valid = 1'b1; i_data = 8'h55;
    tick();
    rst = 1'b0; i_valid = 1'b0;
    nz = 0;
    for (int i = 0; i < BS; i++) if (o_mxint8_elements[i] !== 8'h00) nz++;
    checks++;
    if ({o_ready, o_valid, o_frame_err} !== 3'b100 || o_scale !== 8'h00 || nz != 0) begin
      errors++;
      $display("FAIL rstmid_vals: got rdy/vld/err=%b scale=%h nz=%0d required 100/00/0",
               {o_ready, o_valid, o_frame_err}, o_scale, nz);
    end
    repeat (3) tick();
    // Reset while a block sits in FULL under backpressure
    exp_scale = 8'h5A;
    i_ready = 1'b0;
    stream_block(BS, BS - 1, 0, 1'b0);
    rst = 1'b1; i_ready = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({o_ready, o_valid} !== 2'b10 || o_scale !== 8'h00) begin
      errors++;
      $display("FAIL rstfull_vals: got rdy/vld=%b scale=%h required 10/00",
               {o_ready, o_valid}, o_scale);
    end
    repeat (2) tick();
    checks++;
    if (deliv_cnt != d0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL rst_nodeliv: got deliv=%0d ferr=%0d required 0/0",
               deliv_cnt - d0, ferr_cnt - f0);
    end
    exp_scale = 8'h01;
    for (int k = 0; k < BS; k++) exp_el[k] = 8'(8'h10 + 3 * k);
    stream_block(BS, BS - 1, 0, 1'b0);
    tick();
    checks++;
    if (deliv_cnt - d0 != 1 || payload_bad() != 0) begin
      errors++;
      $display("FAIL rst_next: got deliv=%0d bad=%0d required 1/0",
               deliv_cnt - d0, payload_bad());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_bubbles();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mxint8_block_collector.md
# mxint8_block_collector

Receiving end of the MXINT8 element stream. Accepts one byte-wide beat per cycle over a valid/ready handshake: a shared E8M0 scale, then `BLOCK_SIZE` INT8 elements. Assembles the beats into a full parallel block (`o_scale` plus `o_mxint8_elements[0:BLOCK_SIZE-1]`) in the same array shape that `mxint8_negate` and the other ALU blocks consume. Presents the block downstream with a valid/ready handshake. Sits between the serial load path and the MX ALU datapath.

## Interface

Parameters:
- `ELEMENT_WIDTH`, default 8: INT8 element width; must equal `` `MXINT8_ELEMENT_WIDTH ``.
- `SCALE_WIDTH`, default 8: E8M0 shared-scale width; must be ≤ `ELEMENT_WIDTH`.
- `BLOCK_SIZE`, default 32: elements per block, ≥ 2.

Ports (direction, width, meaning):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `i_valid`, in, 1: input beat valid.
- `o_ready`, out, 1: collector can accept a beat.
- `i_data`, in, `ELEMENT_WIDTH`: beat payload. The scale beat uses bits `[SCALE_WIDTH-1:0]`.
- `i_last`, in, 1: marks the final element beat of a block.
- `o_valid`, out, 1: assembled block valid.
- `i_ready`, in, 1: downstream accepts the block.
- `o_scale`, out, `SCALE_WIDTH`: block shared scale.
- `o_mxint8_elements`, out, `[ELEMENT_WIDTH-1:0] [0:BLOCK_SIZE-1]`: assembled elements. Index 0 is the first element received.
- `o_frame_err`, out, 1: one-cycle pulse on a framing violation.

## Operation

- A beat is accepted when `i_valid && o_ready`. A block is delivered when `o_valid && i_ready`.
- FSM states:
  - SCALE: `o_ready=1`. An accepted beat loads `o_scale`, clears the element counter, and moves to ELEM.
  - ELEM: `o_ready=1`. An accepted beat writes `o_mxint8_elements[cnt]` and increments `cnt`.
    - `cnt==BLOCK_SIZE-1` with `i_last=1`: normal completion, go to FULL.
    - `cnt==BLOCK_SIZE-1` with `i_last=0`: write the element, go to FULL, pulse `o_frame_err` (missing last). The block is still delivered.
    - `cnt<BLOCK_SIZE-1` with `i_last=1`: early last. Write the element, discard the partial block, return to SCALE, pulse `o_frame_err`. No block is delivered.
  - FULL: `o_ready=0`, `o_valid=1`. On `i_ready`, go to SCALE.
- `i_last` on the scale beat is ignored and does not raise an error.
- Counter width is `$clog2(BLOCK_SIZE)`. It never wraps past `BLOCK_SIZE-1`.
- `o_scale` and `o_mxint8_elements` are held stable for as long as `o_valid=1`. Outside FULL their contents are don't-care, and benches must not check them there.
- Payload is passed unchanged: no sign extension, no arithmetic.

## Timing

- Reset values: state=SCALE, `cnt=0`, `o_valid=0`, `o_frame_err=0`, `o_ready=1`, `o_scale=0`, all elements 0.
- `rst` overrides all other inputs in the same cycle. If reset arrives mid-block, the partial block is dropped. If it arrives in FULL, the pending block is dropped without being delivered.
- `o_ready` and `o_valid` are decoded from registered state only. No combinational path runs from `i_valid` or `i_ready` to any output.
- Latency: `o_valid` rises on the edge after the final element beat is accepted.
- Minimum period is `BLOCK_SIZE+2` cycles per block: 1 scale beat, `BLOCK_SIZE` element beats, and 1 FULL cycle when `i_ready=1`. The cycle that accepts the block does not also accept a scale beat.
- `o_frame_err` is registered. It is high for exactly the one cycle after the offending beat is accepted.
- Bubbles (`i_valid=0`) in any state stall without side effects.
- Backpressure in FULL holds the block indefinitely.

## Test plan

- Reset, then stream scale `0x7F` followed by elements `0x00..0x1F` back-to-back, with `i_last` on the 32nd element and `i_ready=1`. Required: `o_valid` high for exactly 1 cycle, on the cycle after the last beat; `o_scale=0x7F`; `element[k]=k`; `o_frame_err` stays 0; `o_ready` returns to 1 on the next cycle.
- Same stream with `i_ready=0` for 5 cycles after `o_valid` rises. Required: `o_valid` and the payload stay constant, `o_ready` stays 0 throughout, and the block is delivered once `i_ready` rises.
- Early last: `i_last` on element index 9. Required: `o_frame_err` pulses for 1 cycle and no `o_valid`. A following correct block (scale `0x80`, elements `0x80..0x9F`) is then delivered intact.
- Missing last on element 31. Required: the block is delivered with correct data and `o_frame_err` pulses once.
- Random `i_valid` bubbles (about 50%) across 3 consecutive blocks with random data. Required: every block matches a scoreboard and `o_frame_err` stays 0.
- Assert `rst` for 1 cycle at element index 17, and separately while in FULL. Required: outputs return to their reset values and no block is delivered. The next full block is collected correctly.
